// File: rtl/pipe_store_buffer.sv
// pipe_store_buffer
//
// Write buffer between the MEM stage and data memory. Stores are queued in a
// circular FIFO and drained to memory one at a time under a mem_we/mem_ack
// handshake. Loads are forwarded from buffered stores (youngest match wins),
// so the pipeline never observes stale memory.
//
// Handshakes:
//   store side : a store is taken on a rising edge when st_valid & st_ready.
//   memory side: the head entry is presented while mem_we is high and retires
//                on a rising edge when mem_we & mem_ack. mem_addr/mem_w_data
//                stay stable until that edge.
//
// Optional feature (macro STBUF_COALESCE_EN): a store whose address equals
// the youngest entry (when at least two entries are buffered) overwrites that
// entry's data instead of allocating, and is accepted even when full.
//
// Ports:
//   clock, reset         : single clock, synchronous active-high reset
//   st_valid/st_addr/st_data/st_ready : store input
//   ld_valid/ld_addr     : load lookup, ld_hit/ld_data combinational result
//   mem_we/mem_addr/mem_w_data/mem_ack : drain to data memory
//   empty, count         : occupancy status
module pipe_store_buffer #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       st_valid,
   input  logic [ADDR_W-1:0]          st_addr,
   input  logic [DATA_W-1:0]          st_data,
   output logic                       st_ready,
   input  logic                       ld_valid,
   input  logic [ADDR_W-1:0]          ld_addr,
   output logic                       ld_hit,
   output logic [DATA_W-1:0]          ld_data,
   output logic                       mem_we,
   output logic [ADDR_W-1:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_w_data,
   input  logic                       mem_ack,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   logic              push;
   logic              pop;
   logic              coalesce_hit;
   logic              coalesce_wr;
   logic [PW-1:0]     youngest_idx;
   logic              any_match;
   logic [DATA_W-1:0] fwd_data;
   logic [PW-1:0]     fwd_idx;

   assign youngest_idx = wr_ptr_q - PW'(1);

`ifdef STBUF_COALESCE_EN
   // With two or more entries the youngest is never the head on the bus,
   // so rewriting its data cannot disturb an in-flight memory write.
   assign coalesce_hit = (count_q >= CW'(2)) && (addr_q[youngest_idx] == st_addr);
`else
   assign coalesce_hit = 1'b0;
`endif

   assign st_ready    = (count_q != CW'(DEPTH)) | coalesce_hit;
   assign coalesce_wr = st_valid & coalesce_hit;
   assign push        = st_valid & st_ready & ~coalesce_hit;
   assign mem_we      = (count_q != '0);
   assign pop         = mem_we & mem_ack;

   assign mem_addr    = addr_q[rd_ptr_q];
   assign mem_w_data  = data_q[rd_ptr_q];
   assign empty       = (count_q == '0);
   assign count       = count_q;

   // Walk entries from oldest to youngest; a later match overrides an
   // earlier one, so the youngest matching entry supplies the data.
   always_comb begin
      any_match = 1'b0;
      fwd_data  = '0;
      fwd_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PW'(i);
         if ((CW'(i) < count_q) && (addr_q[fwd_idx] == ld_addr)) begin
            any_match = 1'b1;
            fwd_data  = data_q[fwd_idx];
         end
      end
   end

   assign ld_hit  = ld_valid & any_match;
   assign ld_data = ld_hit ? fwd_data : '0;

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         if (push) begin
            addr_q[wr_ptr_q] <= st_addr;
            data_q[wr_ptr_q] <= st_data;
         end
         if (coalesce_wr) begin
            data_q[youngest_idx] <= st_data;
         end
      end
   end

endmodule

// File: tb/tb_pipe_store_buffer.sv
// Testbench for pipe_store_buffer. A queue-based model of the buffer
// (oldest entry at index 0) predicts every output each cycle.
module tb_pipe_store_buffer;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CW     = $clog2(DEPTH) + 1;

   // clock / reset
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic              st_valid = 1'b0;
   logic [ADDR_W-1:0] st_addr  = '0;
   logic [DATA_W-1:0] st_data  = '0;
   logic              st_ready;
   logic              ld_valid = 1'b0;
   logic [ADDR_W-1:0] ld_addr  = '0;
   logic              ld_hit;
   logic [DATA_W-1:0] ld_data;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_w_data;
   logic              mem_ack  = 1'b0;
   logic              empty;
   logic [CW-1:0]     count;

   pipe_store_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clock      (clock),
      .reset      (reset),
      .st_valid   (st_valid),
      .st_addr    (st_addr),
      .st_data    (st_data),
      .st_ready   (st_ready),
      .ld_valid   (ld_valid),
      .ld_addr    (ld_addr),
      .ld_hit     (ld_hit),
      .ld_data    (ld_data),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_w_data (mem_w_data),
      .mem_ack    (mem_ack),
      .empty      (empty),
      .count      (count)
   );

   // scoreboard: expected buffer contents, oldest first
   logic [ADDR_W-1:0] exp_addr_q[$];
   logic [DATA_W-1:0] exp_data_q[$];
   logic [ADDR_W-1:0] drained_addr_q[$];
   logic [DATA_W-1:0] drained_data_q[$];
   bit                clean_since_reset = 1'b1;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, check all outputs against the model,
   // then advance the model by what the coming edge does.
   task automatic step(input logic rst, input logic sv, input logic [ADDR_W-1:0] sa,
                       input logic [DATA_W-1:0] sd, input logic lv,
                       input logic [ADDR_W-1:0] la, input logic ack);
      int n;
      logic coal, exp_ready, exp_hit, do_push, do_pop;
      logic [DATA_W-1:0] exp_ld;
      @(negedge clock);
      reset = rst; st_valid = sv; st_addr = sa; st_data = sd;
      ld_valid = lv; ld_addr = la; mem_ack = ack;
      #1;
      n = exp_addr_q.size();
      coal = 1'b0;
`ifdef STBUF_COALESCE_EN
      coal = (n >= 2) && (exp_addr_q[n-1] == sa);
`endif
      exp_ready = (n != DEPTH) || coal;
      exp_hit = 1'b0;
      exp_ld  = '0;
      if (lv) begin
         for (int i = 0; i < n; i++) begin
            if (exp_addr_q[i] == la) begin
               exp_hit = 1'b1;
               exp_ld  = exp_data_q[i];
            end
         end
      end
      check_eq("st_ready", st_ready, exp_ready);
      check_eq("count", count, n);
      check_eq("empty", empty, n == 0);
      check_eq("mem_we", mem_we, n != 0);
      check_eq("ld_hit", ld_hit, exp_hit);
      check_eq("ld_data", ld_data, exp_ld);
      if (n != 0) begin
         check_eq("mem_addr", mem_addr, exp_addr_q[0]);
         check_eq("mem_w_data", mem_w_data, exp_data_q[0]);
      end else if (clean_since_reset) begin
         check_eq("mem_addr_rst", mem_addr, 0);
         check_eq("mem_w_data_rst", mem_w_data, 0);
      end
      if (rst) begin
         exp_addr_q.delete();
         exp_data_q.delete();
         clean_since_reset = 1'b1;
      end else begin
         do_pop  = (n != 0) && ack;
         do_push = sv && exp_ready && !coal;
         if (sv && coal) exp_data_q[n-1] = sd;
         if (do_pop) begin
            drained_addr_q.push_back(exp_addr_q[0]);
            drained_data_q.push_back(exp_data_q[0]);
            void'(exp_addr_q.pop_front());
            void'(exp_data_q.pop_front());
         end
         if (do_push) begin
            exp_addr_q.push_back(sa);
            exp_data_q.push_back(sd);
            clean_since_reset = 1'b0;
         end
      end
   endtask

   task automatic idle(input logic ack);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, ack);
   endtask

   task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input logic ack);
      step(1'b0, 1'b1, a, d, 1'b0, '0, ack);
   endtask

   task automatic do_reset();
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b1);
   endtask

   initial begin
      logic found;
      do_reset();
      do_reset();

      // store reaches memory next cycle, gone one cycle later
      push(32'h10, 32'hAA, 1'b1);
      idle(1'b1);
      idle(1'b1);

      // fill with no ack; fifth store refused; ack reopens st_ready
      for (int i = 0; i < 5; i++) push(32'h100 + 4 * i, 32'h1000 + i, 1'b0);
      idle(1'b1);
      idle(1'b0);
      do_reset();

      // forwarding picks the youngest match; miss returns 0
      push(32'h20, 32'd1, 1'b0);
      push(32'h24, 32'd2, 1'b0);
      push(32'h20, 32'd3, 1'b0);
      step(1'b0, 1'b0, '0, '0, 1'b1, 32'h20, 1'b0);
      check_eq("fwd_youngest", ld_data, 32'd3);
      step(1'b0, 1'b0, '0, '0, 1'b1, 32'h28, 1'b0);
      check_eq("fwd_miss", ld_hit, 1'b0);

      // full buffer, push and ack together across pointer wrap
      push(32'h2C, 32'd4, 1'b0);
      for (int i = 0; i < 8; i++) push(32'h200 + 4 * i, 32'h2000 + i, 1'b1);
      idle(1'b0);

      // reset with count=3 and ack high on the reset edge
      do_reset();
      for (int i = 0; i < 3; i++) push(32'h300 + 4 * i, 32'h3000 + i, 1'b0);
      do_reset();
      step(1'b0, 1'b0, '0, '0, 1'b1, 32'h300, 1'b1);

      // youngest-address re-store; with coalescing it rewrites the entry
      drained_addr_q.delete();
      drained_data_q.delete();
      push(32'h40, 32'h11, 1'b0);
      push(32'h30, 32'h22, 1'b0);
      push(32'h30, 32'h55, 1'b0);
      for (int i = 0; i < 4; i++) idle(1'b1);
      found = 1'b0;
      foreach (drained_addr_q[i])
         if (drained_addr_q[i] == 32'h30 && drained_data_q[i] == 32'h55) found = 1'b1;
      check_eq("drain_0x30_has_0x55", found, 1'b1);

      // randomized traffic over a small address set to exercise hits
      for (int c = 0; c < 3000; c++) begin
         logic rst, sv, lv, ack;
         rst = ($urandom_range(0, 299) == 0);
         sv  = ($urandom_range(0, 3) != 0);
         lv  = $urandom_range(0, 1);
         ack = (c < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
         step(rst, sv, 32'h20 + 4 * $urandom_range(0, 3), $urandom,
              lv, 32'h20 + 4 * $urandom_range(0, 4), ack);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
